q_issue_queue: RTL and testbench

Timed quantum-instruction issue queue sitting directly downstream of `classical_ctrl`. It captures quantum instructions and QWAIT intervals emitted by the controller and tags each instruction with an absolute timeline value. It buffers them in a FIFO and releases each one to the pulse-generation back end only when a free-running run timer reaches its tag. This decouples the controller's variable execution rate from deterministic quantum timing.

---
 rtl/q_issue_if.sv | 22 ++
 rtl/q_issue_queue.sv | 161 ++++++++++++++++
 tb/tb_q_issue_queue.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/q_issue_if.sv
// Instruction capture bus from classical_ctrl plus the timed issue handshake to the back end.
interface q_issue_if;
    logic [63:0] q_inst;
    logic        q_inst_valid;
    logic [1:0]  q_kind;
    logic        q_time_write;
    logic [63:0] q_time_reg;
    logic [63:0] o_inst;
    logic [1:0]  o_kind;
    logic        o_valid;
    logic        i_ready;

    modport master (
        output q_inst, q_inst_valid, q_kind, q_time_write, q_time_reg, i_ready,
        input  o_inst, o_kind, o_valid
    );

    modport slave (
        input  q_inst, q_inst_valid, q_kind, q_time_write, q_time_reg, i_ready,
        output o_inst, o_kind, o_valid
    );
endinterface

// File: rtl/q_issue_queue.sv
// Timed issue queue: tags each captured instruction with the running QWAIT schedule
// and releases it once the run timer reaches that tag.
//   state  | meaning
//   S_IDLE | timer held at 0, queue fills, nothing issues
//   S_RUN  | timer counts, due head entries issue
//   S_DONE | program ended and everything drained
module q_issue_queue #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic                       i_flush,
    input  logic                       i_prog_end,
    q_issue_if.slave                   io_q,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [TS_W-1:0]            o_timeline,
    output logic                       o_overflow,
    output logic                       o_late,
    output logic                       o_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [TS_W-1:0] HALF     = {1'b1, {(TS_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [63:0]     r_mem_inst [DEPTH];
    logic [1:0]      r_mem_kind [DEPTH];
    logic [TS_W-1:0] r_mem_tag  [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [TS_W-1:0] r_t_now, r_t_sched;
    logic            r_end_pend;
    logic [63:0]     r_out_inst;
    logic [1:0]      r_out_kind;
    logic            r_out_valid, r_overflow, r_late;

    logic [TS_W-1:0] w_sched_nxt, w_head_tag, w_head_age, w_sched_age;
    logic w_empty, w_full, w_head_due, w_sched_due, w_pop, w_push, w_drop;
    logic w_done_cond, w_restart;

    // A same-cycle QWAIT already counts towards the tag of a simultaneous push.
    assign w_sched_nxt = io_q.q_time_write ? r_t_sched + io_q.q_time_reg[TS_W-1:0] : r_t_sched;
    assign w_head_tag  = r_mem_tag[r_rd_ptr];
    assign w_head_age  = r_t_now - w_head_tag;
    assign w_sched_age = r_t_now - r_t_sched;
    // Wrap-safe due test: the age is non-negative when its MSB is clear.
    assign w_head_due  = w_head_age < HALF;
    assign w_sched_due = w_sched_age < HALF;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign w_pop       = (r_state == S_RUN) && !w_empty && w_head_due && (!r_out_valid || io_q.i_ready);
    assign w_push      = io_q.q_inst_valid && (!w_full || w_pop);
    assign w_drop      = io_q.q_inst_valid && w_full && !w_pop;
    assign w_done_cond = r_end_pend && w_empty && !r_out_valid && w_sched_due;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        if (i_flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) w_state_nxt = S_RUN;
                S_RUN:  if (w_done_cond) w_state_nxt = S_DONE;
                S_DONE: if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_restart   = 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= io_q.q_inst;
            r_mem_kind[r_wr_ptr] <= io_q.q_kind;
            r_mem_tag[r_wr_ptr]  <= w_sched_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_t_now     <= '0;
            r_t_sched   <= '0;
            r_end_pend  <= 1'b0;
            r_out_inst  <= '0;
            r_out_kind  <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_late      <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_t_now     <= '0;
            r_t_sched   <= '0;
            r_end_pend  <= 1'b0;
            r_out_inst  <= '0;
            r_out_kind  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;

            r_t_sched <= w_restart ? '0 : w_sched_nxt;
            if (w_restart)             r_t_now <= '0;
            else if (r_state == S_RUN) r_t_now <= r_t_now + 1'b1;

            if (w_restart)                              r_end_pend <= 1'b0;
            else if (i_prog_end && r_state != S_DONE)   r_end_pend <= 1'b1;

            if (w_pop) begin
                r_out_inst  <= r_mem_inst[r_rd_ptr];
                r_out_kind  <= r_mem_kind[r_rd_ptr];
                r_out_valid <= 1'b1;
                if (r_t_now != w_head_tag) r_late <= 1'b1;
            end else if (r_out_valid && io_q.i_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_drop) r_overflow <= 1'b1;
        end
    end

    generate
        if (TS_W < 64) begin : g_treg_unused
            logic w_unused_treg;
            assign w_unused_treg = ^io_q.q_time_reg[63:TS_W];
        end
    endgenerate

    assign io_q.o_inst  = r_out_inst;
    assign io_q.o_kind  = r_out_kind;
    assign io_q.o_valid = r_out_valid;
    assign o_full       = w_full;
    assign o_empty      = w_empty;
    assign o_count      = r_count;
    assign o_timeline   = r_t_sched;
    assign o_overflow   = r_overflow;
    assign o_late       = r_late;
    assign o_done       = (r_state == S_DONE);
endmodule

// File: tb/tb_q_issue_queue.sv
// Bench for q_issue_queue: directed schedule table, hand-written corner sequences,
// then random traffic compared every cycle against a queue-based timeline model.
module tb_q_issue_queue;
    localparam int DEPTH = 16;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, flush = 1'b0, prog_end = 1'b0;
    logic        o_full, o_empty, o_overflow, o_late, o_done;
    logic [4:0]  o_count;
    logic [31:0] o_timeline;

    q_issue_if u_if();

    q_issue_queue #(.DEPTH(DEPTH), .TS_W(32)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_flush(flush), .i_prog_end(prog_end),
        .io_q(u_if.slave), .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
        .o_timeline(o_timeline), .o_overflow(o_overflow), .o_late(o_late), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [63:0] inst;
        logic [1:0]  kind;
        logic [31:0] tag;
    } ent_t;

    ent_t        m_q[$];
    int          m_st = M_IDLE;
    logic [31:0] m_now = 0, m_sched = 0;
    bit          m_end = 0, m_valid = 0, m_ov = 0, m_late = 0;
    logic [63:0] m_inst = 0;
    logic [1:0]  m_kind = 0;

    function automatic bit due(input logic [31:0] now, input logic [31:0] tag);
        return $signed(now - tag) >= 0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_st = M_IDLE; m_now = 0; m_sched = 0; m_end = 0;
        m_valid = 0; m_inst = 0; m_kind = 0;
    endtask

    task automatic model_step();
        ent_t e;
        bit pop, full, dcond;
        logic [31:0] sn;
        if (!rst) begin
            model_clear();
            m_ov = 0; m_late = 0;
        end else if (flush) begin
            model_clear();
        end else begin
            full  = (m_q.size() == DEPTH);
            pop   = (m_st == M_RUN) && (m_q.size() != 0) && due(m_now, m_q[0].tag)
                    && (!m_valid || u_if.i_ready);
            dcond = (m_st == M_RUN) && m_end && (m_q.size() == 0) && !m_valid && due(m_now, m_sched);
            sn    = m_sched + (u_if.q_time_write ? u_if.q_time_reg[31:0] : 32'd0);
            if (pop) begin
                e = m_q.pop_front();
                m_valid = 1; m_inst = e.inst; m_kind = e.kind;
                if (e.tag != m_now) m_late = 1;
            end else if (m_valid && u_if.i_ready) begin
                m_valid = 0;
            end
            if (u_if.q_inst_valid) begin
                if (!full || pop) m_q.push_back('{inst: u_if.q_inst, kind: u_if.q_kind, tag: sn});
                else m_ov = 1;
            end
            m_sched = sn;
            if (prog_end && m_st != M_DONE) m_end = 1;
            case (m_st)
                M_IDLE: if (start) begin m_st = M_RUN; m_now = 0; end
                M_RUN: begin
                    m_now = m_now + 1;
                    if (dcond) m_st = M_DONE;
                end
                default: if (start) begin
                    m_st = M_RUN; m_now = 0; m_sched = 0; m_end = 0;
                end
            endcase
        end
    endtask

    task automatic cmp_all();
        chk("mdl_valid", u_if.o_valid, m_valid);
        chk("mdl_inst", u_if.o_inst, m_inst);
        chk("mdl_kind", u_if.o_kind, m_kind);
        chk("mdl_count", o_count, m_q.size());
        chk("mdl_full", o_full, m_q.size() == DEPTH);
        chk("mdl_empty", o_empty, m_q.size() == 0);
        chk("mdl_timeline", o_timeline, m_sched);
        chk("mdl_overflow", o_overflow, m_ov);
        chk("mdl_late", o_late, m_late);
        chk("mdl_done", o_done, m_st == M_DONE);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cmp_all();
    endtask

    task automatic step();
        tick();
        start = 0; flush = 0; prog_end = 0;
        u_if.q_inst_valid = 0; u_if.q_time_write = 0;
    endtask

    task automatic push(input logic [63:0] inst, input logic [1:0] kind);
        u_if.q_inst = inst; u_if.q_kind = kind; u_if.q_inst_valid = 1;
    endtask

    task automatic qwait(input logic [31:0] n);
        u_if.q_time_reg = {32'hDEAD_BEEF, n}; u_if.q_time_write = 1;
    endtask

    typedef struct {
        bit          push;
        logic [63:0] inst;
        logic [1:0]  kind;
        bit          tw;
        logic [31:0] treg;
        bit          start;
        bit          ready;
        bit          exp_valid;
        logic [63:0] exp_inst;
        int          exp_count;
        logic [31:0] exp_tl;
    } vec_t;

    vec_t tbl [15];

    localparam logic [63:0] A = 64'hA000_0000_0000_00AA;
    localparam logic [63:0] B = 64'hB000_0000_0000_00BB;
    localparam logic [63:0] C = 64'hC000_0000_0000_00CC;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1, A, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[1]  = '{0, 0, 2'd0, 1, 5, 0, 0, 0, 0, 1, 5};
        tbl[2]  = '{1, B, 2'd1, 0, 0, 0, 0, 0, 0, 2, 5};
        tbl[3]  = '{1, C, 2'd2, 1, 3, 0, 0, 0, 0, 3, 8};
        tbl[4]  = '{0, 0, 2'd0, 0, 0, 1, 1, 0, 0, 3, 8};
        tbl[5]  = '{0, 0, 2'd0, 0, 0, 0, 1, 1, A, 2, 8};
        tbl[6]  = '{0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 2, 8};
        tbl[7]  = '{0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 2, 8};
        tbl[8]  = '{0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 2, 8};
        tbl[9]  = '{0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 2, 8};
        tbl[10] = '{0, 0, 2'd0, 0, 0, 0, 1, 1, B, 1, 8};
        tbl[11] = '{0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 1, 8};
        tbl[12] = '{0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 1, 8};
        tbl[13] = '{0, 0, 2'd0, 0, 0, 0, 1, 1, C, 0, 8};
        tbl[14] = '{0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 8};

        u_if.q_inst = 0; u_if.q_kind = 0; u_if.q_inst_valid = 0;
        u_if.q_time_write = 0; u_if.q_time_reg = 0; u_if.i_ready = 0;

        // Reset held with random activity on every input.
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom); flush = 1'($urandom); prog_end = 1'($urandom);
            u_if.q_inst = {$urandom, $urandom}; u_if.q_kind = 2'($urandom);
            u_if.q_inst_valid = 1'($urandom); u_if.q_time_write = 1'($urandom);
            u_if.q_time_reg = {$urandom, $urandom}; u_if.i_ready = 1'($urandom);
            tick();
        end
        chk("rst_valid", u_if.o_valid, 0);
        chk("rst_inst", u_if.o_inst, 0);
        chk("rst_count", o_count, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_timeline", o_timeline, 0);
        chk("rst_flags", {o_overflow, o_late, o_done}, 0);
        rst = 1;
        start = 0; flush = 0; prog_end = 0;
        u_if.q_inst_valid = 0; u_if.q_time_write = 0; u_if.i_ready = 0;

        // Schedule: A tag 0, B tag 5, C tag 8; start at row 4.
        for (int i = 0; i < 15; i++) begin
            u_if.q_inst_valid = tbl[i].push; u_if.q_inst = tbl[i].inst; u_if.q_kind = tbl[i].kind;
            u_if.q_time_write = tbl[i].tw; u_if.q_time_reg = {32'hFFFF_0000, tbl[i].treg};
            start = tbl[i].start; u_if.i_ready = tbl[i].ready;
            step();
            chk($sformatf("tbl%0d_valid", i), u_if.o_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_inst", i), u_if.o_inst, tbl[i].exp_inst);
            chk($sformatf("tbl%0d_count", i), o_count, tbl[i].exp_count);
            chk($sformatf("tbl%0d_timeline", i), o_timeline, tbl[i].exp_tl);
            chk($sformatf("tbl%0d_late", i), o_late, 0);
        end

        // Back-pressure: tags 0 and 1, ready low for 4 cycles after A issues.
        flush = 1; step();
        u_if.i_ready = 0;
        push(64'h1111, 2'd0); step();
        push(64'h2222, 2'd1); qwait(1); step();
        start = 1; step();
        step();
        chk("bp_first_valid", u_if.o_valid, 1);
        chk("bp_first_inst", u_if.o_inst, 64'h1111);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("bp_hold%0d_valid", i), u_if.o_valid, 1);
            chk($sformatf("bp_hold%0d_inst", i), u_if.o_inst, 64'h1111);
        end
        chk("bp_late_before", o_late, 0);
        u_if.i_ready = 1; step();
        chk("bp_second_inst", u_if.o_inst, 64'h2222);
        chk("bp_second_kind", u_if.o_kind, 2'd1);
        chk("bp_late_after", o_late, 1);

        // Full with push+pop in the same cycle.
        flush = 1; step();
        for (int i = 0; i < DEPTH; i++) begin push(64'h3000 + i, 2'd3); step(); end
        chk("pp_full", o_full, 1);
        chk("pp_count", o_count, 16);
        start = 1; step();
        push(64'h3FFF, 2'd0); step();
        chk("pp_count_after", o_count, 16);
        chk("pp_overflow", o_overflow, 0);
        chk("pp_issued", u_if.o_inst, 64'h3000);

        // Overflow: 17 pushes in IDLE.
        flush = 1; step();
        for (int i = 0; i < DEPTH; i++) begin push(64'h4000 + i, 2'd2); step(); end
        chk("ov_full16", o_full, 1);
        chk("ov_flag16", o_overflow, 0);
        push(64'h4FFF, 2'd2); step();
        chk("ov_count17", o_count, 16);
        chk("ov_flag17", o_overflow, 1);

        // End of program and a flush mid-run.
        flush = 1; step();
        u_if.i_ready = 1;
        qwait(10); step();
        push(64'h5555, 2'd1); step();
        prog_end = 1; step();
        start = 1; step();
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("end_wait%0d_valid", i), u_if.o_valid, 0);
        end
        step();
        chk("end_x_valid", u_if.o_valid, 1);
        chk("end_x_inst", u_if.o_inst, 64'h5555);
        step();
        chk("end_done_early", o_done, 0);
        step();
        chk("end_done", o_done, 1);
        start = 1; step();
        chk("run2_done", o_done, 0);
        chk("run2_timeline", o_timeline, 0);
        qwait(50); push(64'h6666, 2'd0); step();
        step(); step();
        chk("run2_timeline_pre", o_timeline, 50);
        flush = 1; step();
        chk("flush_empty", o_empty, 1);
        chk("flush_valid", u_if.o_valid, 0);
        chk("flush_timeline", o_timeline, 0);
        chk("flush_done", o_done, 0);

        // Random traffic against the model.
        rst = 0; step(); rst = 1;
        for (int i = 0; i < 4000; i++) begin
            rst               = ($urandom_range(0, 399) != 0);
            start             = ($urandom_range(0, 29) == 0);
            flush             = ($urandom_range(0, 199) == 0);
            prog_end          = ($urandom_range(0, 59) == 0);
            u_if.q_inst_valid = 1'($urandom);
            u_if.q_inst       = {$urandom, $urandom};
            u_if.q_kind       = 2'($urandom);
            u_if.q_time_write = ($urandom_range(0, 4) == 0);
            u_if.q_time_reg   = {$urandom, 32'($urandom_range(0, 4))};
            u_if.i_ready      = ($urandom_range(0, 9) < 7);
            step();
            rst = 1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
